rs_age_station: RTL and testbench

- Parametrised reservation station that generalises the fixed 16-entry busy/Q helpers.
- Configurable depth, tag and data width, and number of CDB wakeup channels.
- Stores dispatched ops, captures operands from CDB broadcasts, and issues the oldest ready entry through a registered valid/ready output stage.
- Sits between dispatch and one functional unit; used for the ALU and branch stations.

---
 rtl/rs_age_station.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_rs_age_station.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/rs_age_station.sv
`default_nettype none
// ============================================================================
// Module      : rs_age_station
// Description : Parametrised reservation station with age-matrix selection.
//               Holds dispatched ops, captures operands from CDB broadcasts
//               and issues the oldest ready entry through a registered
//               valid/ready output stage.
// Ports       : clk_in/rst_in     clock, async active-high reset
//               rdy_in/flush_in   global enable, misprediction flush
//               disp_*            dispatch request and op fields
//               cdb_*             packed CDB broadcast channels (ch0 in LSBs)
//               issue_*           registered issue stage towards the FU
//               count_out/full/one_left  occupancy from registered state
// Revision    : 1.0  initial release
// ============================================================================
module rs_age_station #(
   parameter int DEPTH   = 16,
   parameter int TAG_W   = 5,
   parameter int XLEN    = 32,
   parameter int OP_W    = 6,
   parameter int NUM_CDB = 2
) (
   input  logic                       clk_in,
   input  logic                       rst_in,
   input  logic                       rdy_in,
   input  logic                       flush_in,
   input  logic                       disp_valid,
   output logic                       disp_ready,
   input  logic [OP_W-1:0]            disp_op,
   input  logic [XLEN-1:0]            disp_vj,
   input  logic [XLEN-1:0]            disp_vk,
   input  logic [TAG_W-1:0]           disp_qj,
   input  logic [TAG_W-1:0]           disp_qk,
   input  logic [TAG_W-1:0]           disp_dest,
   input  logic [NUM_CDB-1:0]         cdb_valid,
   input  logic [NUM_CDB*TAG_W-1:0]   cdb_tag,
   input  logic [NUM_CDB*XLEN-1:0]    cdb_value,
   output logic                       issue_valid,
   input  logic                       issue_ready,
   output logic [OP_W-1:0]            issue_op,
   output logic [TAG_W-1:0]           issue_dest,
   output logic [XLEN-1:0]            issue_vj,
   output logic [XLEN-1:0]            issue_vk,
   output logic [$clog2(DEPTH+1)-1:0] count_out,
   output logic                       full,
   output logic                       one_left
);

   localparam int CNT_W = $clog2(DEPTH+1);
   localparam int IDX_W = $clog2(DEPTH);

   // Entry storage
   logic             busy_q [DEPTH];
   logic             busy_d [DEPTH];
   logic [OP_W-1:0]  op_q   [DEPTH];
   logic [OP_W-1:0]  op_d   [DEPTH];
   logic [XLEN-1:0]  vj_q   [DEPTH];
   logic [XLEN-1:0]  vj_d   [DEPTH];
   logic [XLEN-1:0]  vk_q   [DEPTH];
   logic [XLEN-1:0]  vk_d   [DEPTH];
   logic [TAG_W-1:0] qj_q   [DEPTH];
   logic [TAG_W-1:0] qj_d   [DEPTH];
   logic [TAG_W-1:0] qk_q   [DEPTH];
   logic [TAG_W-1:0] qk_d   [DEPTH];
   logic [TAG_W-1:0] dest_q [DEPTH];
   logic [TAG_W-1:0] dest_d [DEPTH];
   // older_q[i][j] = 1 : entry i is older than entry j
   logic [DEPTH-1:0] older_q [DEPTH];
   logic [DEPTH-1:0] older_d [DEPTH];

   logic [CNT_W-1:0] count_q, count_d;

   logic             issue_valid_q, issue_valid_d;
   logic [OP_W-1:0]  issue_op_q,    issue_op_d;
   logic [TAG_W-1:0] issue_dest_q,  issue_dest_d;
   logic [XLEN-1:0]  issue_vj_q,    issue_vj_d;
   logic [XLEN-1:0]  issue_vk_q,    issue_vk_d;

   // Unpacked CDB channels
   logic [TAG_W-1:0] cdb_tag_w [NUM_CDB];
   logic [XLEN-1:0]  cdb_val_w [NUM_CDB];

   genvar gc;
   generate
      for (gc = 0; gc < NUM_CDB; gc++) begin : g_cdb
         assign cdb_tag_w[gc] = cdb_tag[gc*TAG_W +: TAG_W];
         assign cdb_val_w[gc] = cdb_value[gc*XLEN +: XLEN];
      end
   endgenerate

   // Occupancy flags come straight from the registered count
   assign count_out  = count_q;
   assign full       = (count_q == CNT_W'(DEPTH));
   assign one_left   = (count_q == CNT_W'(DEPTH-1));
   assign disp_ready = rdy_in && !full && !flush_in;

   assign issue_valid = issue_valid_q;
   assign issue_op    = issue_op_q;
   assign issue_dest  = issue_dest_q;
   assign issue_vj    = issue_vj_q;
   assign issue_vk    = issue_vk_q;

   // Ready vector, oldest-ready select and lowest free slot
   logic [DEPTH-1:0] ready_w;
   logic             any_ready;
   logic [IDX_W-1:0] sel_idx;
   logic [IDX_W-1:0] free_idx;
   logic             blocked;

   always_comb begin
      ready_w  = '0;
      sel_idx  = '0;
      free_idx = '0;
      blocked  = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         ready_w[i] = busy_q[i] && (qj_q[i] == '0) && (qk_q[i] == '0);
      end
      any_ready = |ready_w;
      // An entry wins when no other ready entry is older than it
      for (int i = 0; i < DEPTH; i++) begin
         blocked = 1'b0;
         for (int j = 0; j < DEPTH; j++) begin
            if (ready_w[j] && older_q[j][i]) blocked = 1'b1;
         end
         if (ready_w[i] && !blocked) sel_idx = IDX_W'(i);
      end
      // Descending scan leaves the lowest vacant index
      for (int i = DEPTH-1; i >= 0; i--) begin
         if (!busy_q[i]) free_idx = IDX_W'(i);
      end
   end

   // Dispatch-time bypass from same-cycle CDB; descending scan so the
   // lowest matching channel has the final word.
   logic            byp_j_hit, byp_k_hit;
   logic [XLEN-1:0] byp_j_val, byp_k_val;

   always_comb begin
      byp_j_hit = 1'b0;
      byp_k_hit = 1'b0;
      byp_j_val = '0;
      byp_k_val = '0;
      for (int c = NUM_CDB-1; c >= 0; c--) begin
         if (cdb_valid[c] && (cdb_tag_w[c] != '0)) begin
            if (disp_qj == cdb_tag_w[c]) begin
               byp_j_hit = 1'b1;
               byp_j_val = cdb_val_w[c];
            end
            if (disp_qk == cdb_tag_w[c]) begin
               byp_k_hit = 1'b1;
               byp_k_val = cdb_val_w[c];
            end
         end
      end
   end

   logic disp_fire, issue_load;
   assign disp_fire  = disp_valid && disp_ready;
   assign issue_load = rdy_in && !flush_in && (!issue_valid_q || issue_ready) && any_ready;

   always_comb begin
      busy_d        = busy_q;
      op_d          = op_q;
      vj_d          = vj_q;
      vk_d          = vk_q;
      qj_d          = qj_q;
      qk_d          = qk_q;
      dest_d        = dest_q;
      older_d       = older_q;
      count_d       = count_q;
      issue_valid_d = issue_valid_q;
      issue_op_d    = issue_op_q;
      issue_dest_d  = issue_dest_q;
      issue_vj_d    = issue_vj_q;
      issue_vk_d    = issue_vk_q;

      if (rdy_in) begin
         if (flush_in) begin
            for (int i = 0; i < DEPTH; i++) begin
               busy_d[i]  = 1'b0;
               older_d[i] = '0;
            end
            count_d       = '0;
            issue_valid_d = 1'b0;
         end else begin
            // Wakeup: compare against registered tags, lowest channel wins
            for (int i = 0; i < DEPTH; i++) begin
               for (int c = NUM_CDB-1; c >= 0; c--) begin
                  if (busy_q[i] && cdb_valid[c] && (cdb_tag_w[c] != '0)) begin
                     if (qj_q[i] == cdb_tag_w[c]) begin
                        vj_d[i] = cdb_val_w[c];
                        qj_d[i] = '0;
                     end
                     if (qk_q[i] == cdb_tag_w[c]) begin
                        vk_d[i] = cdb_val_w[c];
                        qk_d[i] = '0;
                     end
                  end
               end
            end

            if (issue_load) begin
               issue_valid_d    = 1'b1;
               issue_op_d       = op_q[sel_idx];
               issue_dest_d     = dest_q[sel_idx];
               issue_vj_d       = vj_q[sel_idx];
               issue_vk_d       = vk_q[sel_idx];
               busy_d[sel_idx]  = 1'b0;
               older_d[sel_idx] = '0;
               for (int j = 0; j < DEPTH; j++) older_d[j][sel_idx] = 1'b0;
            end else if (issue_ready) begin
               issue_valid_d = 1'b0;
            end

            // free_idx is vacant now, so it never collides with sel_idx
            if (disp_fire) begin
               busy_d[free_idx] = 1'b1;
               op_d[free_idx]   = disp_op;
               dest_d[free_idx] = disp_dest;
               if (disp_qj != '0 && byp_j_hit) begin
                  vj_d[free_idx] = byp_j_val;
                  qj_d[free_idx] = '0;
               end else begin
                  vj_d[free_idx] = disp_vj;
                  qj_d[free_idx] = disp_qj;
               end
               if (disp_qk != '0 && byp_k_hit) begin
                  vk_d[free_idx] = byp_k_val;
                  qk_d[free_idx] = '0;
               end else begin
                  vk_d[free_idx] = disp_vk;
                  qk_d[free_idx] = disp_qk;
               end
               older_d[free_idx] = '0;
               for (int k = 0; k < DEPTH; k++) begin
                  older_d[k][free_idx] = busy_q[k] && !(issue_load && (sel_idx == IDX_W'(k)));
               end
            end

            count_d = count_q + CNT_W'(disp_fire) - CNT_W'(issue_load);
         end
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         for (int i = 0; i < DEPTH; i++) begin
            busy_q[i]  <= 1'b0;
            op_q[i]    <= '0;
            vj_q[i]    <= '0;
            vk_q[i]    <= '0;
            qj_q[i]    <= '0;
            qk_q[i]    <= '0;
            dest_q[i]  <= '0;
            older_q[i] <= '0;
         end
         count_q       <= '0;
         issue_valid_q <= 1'b0;
         issue_op_q    <= '0;
         issue_dest_q  <= '0;
         issue_vj_q    <= '0;
         issue_vk_q    <= '0;
      end else begin
         busy_q        <= busy_d;
         op_q          <= op_d;
         vj_q          <= vj_d;
         vk_q          <= vk_d;
         qj_q          <= qj_d;
         qk_q          <= qk_d;
         dest_q        <= dest_d;
         older_q       <= older_d;
         count_q       <= count_d;
         issue_valid_q <= issue_valid_d;
         issue_op_q    <= issue_op_d;
         issue_dest_q  <= issue_dest_d;
         issue_vj_q    <= issue_vj_d;
         issue_vk_q    <= issue_vk_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_rs_age_station.sv
`default_nettype none
// ============================================================================
// Module      : tb_rs_age_station
// Description : Randomised self-checking bench for rs_age_station. The
//               reference model keeps entries in a queue in dispatch order,
//               so the oldest ready op is simply the first ready element.
// Revision    : 1.0  initial release
// ============================================================================
module tb_rs_age_station;

   localparam int DEPTH   = 16;
   localparam int TAG_W   = 5;
   localparam int XLEN    = 32;
   localparam int OP_W    = 6;
   localparam int NUM_CDB = 2;
   localparam int CNT_W   = $clog2(DEPTH+1);

   logic                     clk_in = 1'b0;
   logic                     rst_in;
   logic                     rdy_in;
   logic                     flush_in;
   logic                     disp_valid;
   logic                     disp_ready;
   logic [OP_W-1:0]          disp_op;
   logic [XLEN-1:0]          disp_vj, disp_vk;
   logic [TAG_W-1:0]         disp_qj, disp_qk, disp_dest;
   logic [NUM_CDB-1:0]       cdb_valid;
   logic [NUM_CDB*TAG_W-1:0] cdb_tag;
   logic [NUM_CDB*XLEN-1:0]  cdb_value;
   logic                     issue_valid;
   logic                     issue_ready;
   logic [OP_W-1:0]          issue_op;
   logic [TAG_W-1:0]         issue_dest;
   logic [XLEN-1:0]          issue_vj, issue_vk;
   logic [CNT_W-1:0]         count_out;
   logic                     full, one_left;

   rs_age_station #(
      .DEPTH(DEPTH), .TAG_W(TAG_W), .XLEN(XLEN), .OP_W(OP_W), .NUM_CDB(NUM_CDB)
   ) dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
      .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op),
      .disp_vj(disp_vj), .disp_vk(disp_vk), .disp_qj(disp_qj), .disp_qk(disp_qk),
      .disp_dest(disp_dest), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
      .cdb_value(cdb_value), .issue_valid(issue_valid), .issue_ready(issue_ready),
      .issue_op(issue_op), .issue_dest(issue_dest), .issue_vj(issue_vj),
      .issue_vk(issue_vk), .count_out(count_out), .full(full), .one_left(one_left)
   );

   always #5 clk_in = ~clk_in;

   typedef struct {
      logic [OP_W-1:0]  op;
      logic [XLEN-1:0]  vj;
      logic [XLEN-1:0]  vk;
      logic [TAG_W-1:0] qj;
      logic [TAG_W-1:0] qk;
      logic [TAG_W-1:0] dest;
   } ent_t;

   ent_t m_q[$];      // busy entries, oldest first
   ent_t m_is;        // issue register contents
   logic m_iv;        // issue register valid

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // {hit, value} of the lowest CDB channel broadcasting tag t
   function automatic logic [XLEN:0] cdb_lookup(input logic [TAG_W-1:0] t);
      logic [TAG_W-1:0] ct;
      if (t == '0) return '0;
      for (int c = 0; c < NUM_CDB; c++) begin
         ct = cdb_tag[c*TAG_W +: TAG_W];
         if (cdb_valid[c] && ct != '0 && ct == t)
            return {1'b1, cdb_value[c*XLEN +: XLEN]};
      end
      return '0;
   endfunction

   task automatic model_reset();
      m_q.delete();
      m_iv = 1'b0;
      m_is = '{op: '0, vj: '0, vk: '0, qj: '0, qk: '0, dest: '0};
   endtask

   // Advance the model by one clock edge using the currently driven inputs
   task automatic model_step();
      int          sel;
      bit          load;
      bit          was_full;
      logic [XLEN:0] h;
      ent_t        e;
      if (!rdy_in) return;
      if (flush_in) begin
         m_q.delete();
         m_iv = 1'b0;
         return;
      end
      was_full = (m_q.size() == DEPTH);
      sel = -1;
      foreach (m_q[i]) if (sel < 0 && m_q[i].qj == '0 && m_q[i].qk == '0) sel = i;
      load = (sel >= 0) && (!m_iv || issue_ready);
      if (load) begin
         m_is = m_q[sel];
         m_q.delete(sel);
      end
      foreach (m_q[i]) begin
         h = cdb_lookup(m_q[i].qj);
         if (h[XLEN]) begin m_q[i].vj = h[XLEN-1:0]; m_q[i].qj = '0; end
         h = cdb_lookup(m_q[i].qk);
         if (h[XLEN]) begin m_q[i].vk = h[XLEN-1:0]; m_q[i].qk = '0; end
      end
      if (disp_valid && !was_full) begin
         e.op = disp_op; e.dest = disp_dest;
         e.vj = disp_vj; e.qj = disp_qj;
         e.vk = disp_vk; e.qk = disp_qk;
         h = cdb_lookup(disp_qj);
         if (h[XLEN]) begin e.vj = h[XLEN-1:0]; e.qj = '0; end
         h = cdb_lookup(disp_qk);
         if (h[XLEN]) begin e.vk = h[XLEN-1:0]; e.qk = '0; end
         m_q.push_back(e);
      end
      if (load) m_iv = 1'b1;
      else if (issue_ready) m_iv = 1'b0;
   endtask

   task automatic compare_outputs();
      check_val("issue_valid", 64'(issue_valid), 64'(m_iv));
      check_val("issue_op",    64'(issue_op),    64'(m_is.op));
      check_val("issue_dest",  64'(issue_dest),  64'(m_is.dest));
      check_val("issue_vj",    64'(issue_vj),    64'(m_is.vj));
      check_val("issue_vk",    64'(issue_vk),    64'(m_is.vk));
      check_val("count_out",   64'(count_out),   64'(m_q.size()));
      check_val("full",        64'(full),        64'(m_q.size() == DEPTH));
      check_val("one_left",    64'(one_left),    64'(m_q.size() == DEPTH-1));
   endtask

   function automatic bit pct(input int p);
      return ($urandom_range(0, 99) < p);
   endfunction

   function automatic logic [TAG_W-1:0] dep_tag(input int p);
      return pct(p) ? TAG_W'($urandom_range(1, 3)) : '0;
   endfunction

   // One phase of random traffic; each cycle: check, drive, step model
   task automatic run_phase(input int cycles, input int p_disp, input int p_dep,
                            input int p_cdb, input int p_ir, input int p_flush,
                            input int p_rdy);
      bit exp_rdy;
      for (int n = 0; n < cycles; n++) begin
         compare_outputs();
         rdy_in      = pct(p_rdy);
         flush_in    = pct(p_flush);
         issue_ready = pct(p_ir);
         disp_valid  = pct(p_disp);
         disp_op     = OP_W'($urandom);
         disp_dest   = TAG_W'($urandom);
         disp_vj     = $urandom;
         disp_vk     = $urandom;
         disp_qj     = dep_tag(p_dep);
         disp_qk     = dep_tag(p_dep);
         for (int c = 0; c < NUM_CDB; c++) begin
            cdb_valid[c]                  = pct(p_cdb);
            cdb_tag[c*TAG_W +: TAG_W]     = TAG_W'($urandom_range(0, 3));
            cdb_value[c*XLEN +: XLEN]     = $urandom;
         end
         #1;
         exp_rdy = rdy_in && (m_q.size() < DEPTH) && !flush_in;
         check_val("disp_ready", 64'(disp_ready), 64'(exp_rdy));
         model_step();
         @(negedge clk_in);
      end
   endtask

   initial begin
      rst_in = 1'b1; rdy_in = 1'b0; flush_in = 1'b0; disp_valid = 1'b0;
      disp_op = '0; disp_vj = '0; disp_vk = '0; disp_qj = '0; disp_qk = '0;
      disp_dest = '0; cdb_valid = '0; cdb_tag = '0; cdb_value = '0;
      issue_ready = 1'b0;
      model_reset();
      repeat (2) @(posedge clk_in);
      @(negedge clk_in);
      compare_outputs();
      rst_in = 1'b0;

      //        cycles disp dep cdb  ir flush rdy
      run_phase(300,    60,  40, 50, 70, 1,   90);
      run_phase(120,    95,  90,  5, 20, 0,  100);   // fills the station
      run_phase(150,     0,  50, 80, 80, 0,  100);   // drains it
      run_phase(250,    70,  50, 40, 15, 0,   95);   // heavy backpressure
      run_phase(200,    80,  60, 50, 60, 8,   85);   // frequent flushes

      // Asynchronous reset in the middle of a cycle clears immediately
      run_phase(60,     95,  90,  5, 10, 0,  100);
      #2 rst_in = 1'b1;
      #1;
      model_reset();
      compare_outputs();
      @(negedge clk_in);
      rst_in = 1'b0;
      run_phase(200,    60,  40, 50, 70, 1,   90);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
